// File: rtl/ps2_rx_fifo_if.sv
// ============================================================================
// Module      : ps2_rx_fifo_if
// Description : Host-side bus of the PS/2 receive FIFO. The host (master)
//               issues pop / error-clear strobes and observes the FIFO head,
//               occupancy and the sticky error flags driven by the receiver
//               (slave).
//   rd          pop strobe (one pop per high cycle)
//   clr_err     clears the sticky error flags
//   data        FIFO head byte, valid while ready=1
//   ready       FIFO non-empty
//   count       FIFO occupancy
//   overflow    sticky: good byte dropped on a full FIFO
//   parity_err  sticky: frame discarded for bad parity
//   frame_err   sticky: bad stop bit or timeout abort
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ps2_rx_fifo_if #(
    parameter int DEPTH = 8
);
    logic                     rd;
    logic                     clr_err;
    logic [7:0]               data;
    logic                     ready;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     parity_err;
    logic                     frame_err;

    modport master (
        output rd,
        output clr_err,
        input  data,
        input  ready,
        input  count,
        input  overflow,
        input  parity_err,
        input  frame_err
    );

    modport slave (
        input  rd,
        input  clr_err,
        output data,
        output ready,
        output count,
        output overflow,
        output parity_err,
        output frame_err
    );
endinterface

`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
// ============================================================================
// Module      : ps2_rx_fifo
// Description : PS/2 device-to-host receiver with a show-ahead byte FIFO.
//               Synchronises both PS/2 pins, deglitches the PS/2 clock,
//               deframes 11-bit frames (start, 8 data LSB-first, odd parity,
//               stop) and queues good bytes. Runs entirely on HCLK.
//   HCLK        system clock (rising edge)
//   HRESETn     asynchronous active-low reset
//   ps2_clk     raw PS/2 clock pin (asynchronous)
//   ps2_data    raw PS/2 data pin (asynchronous)
//   bus         host side: rd / clr_err in; data, ready, count,
//               overflow, parity_err, frame_err out
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_rx_fifo #(
    parameter int DEPTH   = 8,
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 50000
) (
    input  wire logic          HCLK,
    input  wire logic          HRESETn,
    input  wire logic          ps2_clk,
    input  wire logic          ps2_data,
    ps2_rx_fifo_if.slave       bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [7:0]    FILT_LAST = 8'(FILTER - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // ------------------------------------------------------------------
    // Pin synchronisers. Reset to 1 so an idle (high) bus does not look
    // like an edge when reset is released.
    // ------------------------------------------------------------------
    logic clk_meta_q, clk_sync_q;
    logic dat_meta_q, dat_sync_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2_data;
            dat_sync_q <= dat_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Clock deglitch filter: the filtered clock only follows the
    // synchronised clock after FILTER consecutive differing samples.
    // ------------------------------------------------------------------
    logic [7:0] flt_cnt_q, flt_cnt_d;
    logic       clk_flt_q, clk_flt_d;
    logic       clk_prev_q;
    logic       fall;

    always_comb begin
        flt_cnt_d = 8'd0;
        clk_flt_d = clk_flt_q;
        if (clk_sync_q != clk_flt_q) begin
            if (flt_cnt_q == FILT_LAST) begin
                clk_flt_d = clk_sync_q;
            end else begin
                flt_cnt_d = flt_cnt_q + 8'd1;
            end
        end
    end

    assign fall = clk_prev_q & ~clk_flt_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            flt_cnt_q  <= 8'd0;
            clk_flt_q  <= 1'b1;
            clk_prev_q <= 1'b1;
        end else begin
            flt_cnt_q  <= flt_cnt_d;
            clk_flt_q  <= clk_flt_d;
            clk_prev_q <= clk_flt_q;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM with inactivity timeout
    // ------------------------------------------------------------------
    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          push_req;
    logic          perr_set;
    logic          ferr_set;

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        to_cnt_d  = to_cnt_q;
        push_req  = 1'b0;
        perr_set  = 1'b0;
        ferr_set  = 1'b0;

        if (state_q == ST_IDLE) begin
            to_cnt_d = '0;
            // A fall with data high is not a start bit; it is ignored.
            if (fall && !dat_sync_q) begin
                state_d   = ST_DATA;
                bit_idx_d = 3'd0;
                shift_d   = 8'd0;
            end
        end else if (fall) begin
            // A real edge always wins over a coincident timeout.
            to_cnt_d = '0;
            case (state_q)
                ST_DATA: begin
                    shift_d   = {dat_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = dat_sync_q;
                    state_d = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                    if (!dat_sync_q) begin
                        ferr_set = 1'b1;
                    end else if (^{shift_q, par_q}) begin
                        push_req = 1'b1;
                    end else begin
                        perr_set = 1'b1;
                    end
                end
            endcase
        end else if (to_cnt_q == TO_LAST) begin
            state_d  = ST_IDLE;
            ferr_set = 1'b1;
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Byte FIFO. A pop in the same cycle frees the slot a push needs,
    // so a full FIFO with a concurrent pop still accepts the byte.
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;
    logic          pop_ok;
    logic          push_ok;
    logic          ovf_set;

    always_comb begin
        pop_ok  = bus.rd && (count_q != '0);
        push_ok = push_req && ((count_q != FULL_CNT) || pop_ok);
        ovf_set = push_req && (count_q == FULL_CNT) && !pop_ok;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end

        // Set events take priority over a coincident clear.
        overflow_d   = ovf_set  | (overflow_q   & ~bus.clr_err);
        parity_err_d = perr_set | (parity_err_q & ~bus.clr_err);
        frame_err_d  = ferr_set | (frame_err_q  & ~bus.clr_err);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.data       = mem_q[rd_ptr_q];
    assign bus.ready      = (count_q != '0);
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
// ============================================================================
// Module      : tb_ps2_rx_fifo
// Description : Self-checking bench for ps2_rx_fifo. Table of single-frame
//               vectors plus hand-written sequences for overflow, pop on the
//               push cycle, timeout, glitches and mid-frame reset. Good bytes
//               are queued on a scoreboard when sent and compared on pop.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ps2_rx_fifo;

    localparam int DEPTH   = 8;
    localparam int FILTER  = 8;
    localparam int TIMEOUT = 2000;
    localparam int HALF    = 40;   // PS/2 half period in HCLK cycles

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    ps2_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    ps2_rx_fifo #(
        .DEPTH   (DEPTH),
        .FILTER  (FILTER),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    always #5 HCLK = ~HCLK;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] b;
        bit         pflip;
        bit         stop;
        bit         exp_push;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // strobe: 0 none, 1 rd, 2 clr_err -- asserted for the one cycle in which
    // the DUT sees the filtered falling edge of this bit (2 sync + FILTER
    // filter + 1 edge-detect flops after the pin falls).
    task automatic send_bit(input bit b, input int strobe, input bit glitch);
        @(negedge HCLK);
        ps2_data = b;
        if (glitch) begin
            repeat (HALF / 2) @(negedge HCLK);
            ps2_clk = 1'b0;
            repeat (FILTER - 2) @(negedge HCLK);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge HCLK);
        ps2_clk = 1'b0;
        if (strobe != 0) begin
            repeat (2 + FILTER) @(posedge HCLK);
            @(negedge HCLK);
            if (strobe == 1) bus.rd = 1'b1;
            else bus.clr_err = 1'b1;
            @(negedge HCLK);
            bus.rd = 1'b0;
            bus.clr_err = 1'b0;
        end
        if (glitch) begin
            repeat (HALF / 2) @(negedge HCLK);
            ps2_clk = 1'b1;
            repeat (FILTER - 2) @(negedge HCLK);
            ps2_clk = 1'b0;
        end
        repeat (HALF) @(negedge HCLK);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit pflip, input bit stop,
                              input int strobe, input int nbits, input bit glitch);
        logic [10:0] bits;
        bits = {stop, (~(^b)) ^ pflip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            send_bit(bits[i], (i == 10) ? strobe : 0, glitch && (i >= 2) && (i <= 6));
        end
        repeat (4) @(negedge HCLK);
    endtask

    task automatic pop_check(input string name);
        logic [7:0] e;
        @(negedge HCLK);
        if (exp_q.size() == 0) begin
            chk({name, "_empty_ready"}, int'(bus.ready), 0);
        end else begin
            e = exp_q.pop_front();
            chk(name, int'({bus.ready, bus.data}), int'({1'b1, e}));
            bus.rd = 1'b1;
            @(negedge HCLK);
            bus.rd = 1'b0;
        end
    endtask

    task automatic clear_errs();
        @(negedge HCLK);
        bus.clr_err = 1'b1;
        @(negedge HCLK);
        bus.clr_err = 1'b0;
        @(negedge HCLK);
    endtask

    task automatic chk_flags(input string name, input int ovf, input int perr, input int ferr);
        chk({name, "_overflow"},   int'(bus.overflow),   ovf);
        chk({name, "_parity_err"}, int'(bus.parity_err), perr);
        chk({name, "_frame_err"},  int'(bus.frame_err),  ferr);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rd = 1'b0;
        bus.clr_err = 1'b0;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h29, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge HCLK);
        chk("reset_out", int'({bus.ready, bus.count, bus.data}), 0);
        chk_flags("reset", 0, 0, 0);
        HRESETn = 1'b1;
        repeat (5) @(negedge HCLK);
        chk("post_reset_count", int'(bus.count), 0);

        // Pop on empty FIFO must not underflow
        bus.rd = 1'b1;
        @(negedge HCLK);
        bus.rd = 1'b0;
        @(negedge HCLK);
        chk("empty_pop_count", int'(bus.count), 0);

        // Table-driven single frames
        foreach (vecs[v]) begin
            send_frame(vecs[v].b, vecs[v].pflip, vecs[v].stop, 0, 11, 1'b0);
            if (vecs[v].exp_push) exp_q.push_back(vecs[v].b);
            chk($sformatf("vec%0d_count", v), int'(bus.count), int'(vecs[v].exp_push));
            chk_flags($sformatf("vec%0d", v), 0, int'(vecs[v].exp_perr), int'(vecs[v].exp_ferr));
            pop_check($sformatf("vec%0d_data", v));
            @(negedge HCLK);
            chk($sformatf("vec%0d_drained", v), int'({bus.ready, bus.count}), 0);
            clear_errs();
            chk_flags($sformatf("vec%0d_clr", v), 0, 0, 0);
        end

        // clr_err on the same cycle as a parity-error set: set wins
        send_frame(8'h1C, 1'b1, 1'b1, 2, 11, 1'b0);
        chk("clr_collide_perr", int'(bus.parity_err), 1);
        clear_errs();
        chk("clr_after_collide", int'(bus.parity_err), 0);

        // Overflow: 9 frames, no pops; 0x09 is lost
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b0, 1'b1, 0, 11, 1'b0);
            if (i <= DEPTH) exp_q.push_back(8'(i));
        end
        chk("ovf_count", int'(bus.count), 8);
        chk("ovf_flag", int'(bus.overflow), 1);
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("ovf_pop%0d", i));
        pop_check("ovf_after");
        clear_errs();

        // Full FIFO with a pop on the exact push cycle
        for (int i = 1; i <= 8; i++) begin
            send_frame(8'(i), 1'b0, 1'b1, 0, 11, 1'b0);
            exp_q.push_back(8'(i));
        end
        chk("sim_full_count", int'(bus.count), 8);
        chk("sim_head", int'(bus.data), int'(exp_q.pop_front()));
        send_frame(8'h09, 1'b0, 1'b1, 1, 11, 1'b0);
        exp_q.push_back(8'h09);
        chk("sim_count", int'(bus.count), 8);
        chk("sim_overflow", int'(bus.overflow), 0);
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("sim_pop%0d", i));
        pop_check("sim_after");

        // Timeout: abandon after start + 4 data bits
        send_frame(8'h33, 1'b0, 1'b1, 0, 5, 1'b0);
        repeat (TIMEOUT / 2) @(negedge HCLK);
        chk("to_early", int'(bus.frame_err), 0);
        repeat (TIMEOUT) @(negedge HCLK);
        chk("to_ferr", int'(bus.frame_err), 1);
        clear_errs();
        send_frame(8'h29, 1'b0, 1'b1, 0, 11, 1'b0);
        exp_q.push_back(8'h29);
        chk_flags("to_next", 0, 0, 0);
        pop_check("to_next_data");

        // Glitches on ps2_clk shorter than FILTER cycles
        send_frame(8'hA7, 1'b0, 1'b1, 0, 11, 1'b1);
        exp_q.push_back(8'hA7);
        chk("glitch_count", int'(bus.count), 1);
        chk_flags("glitch", 0, 0, 0);
        pop_check("glitch_data");

        // Asynchronous reset mid-frame with data and a flag present
        send_frame(8'h11, 1'b0, 1'b1, 0, 11, 1'b0);
        send_frame(8'h12, 1'b1, 1'b1, 0, 11, 1'b0);
        chk("prerst_state", int'({bus.ready, bus.parity_err}), 3);
        send_frame(8'h77, 1'b0, 1'b1, 0, 4, 1'b0);
        ps2_clk = 1'b0;
        #3;
        HRESETn = 1'b0;
        #1;
        chk("rst_mid_out", int'({bus.ready, bus.count, bus.data}), 0);
        chk_flags("rst_mid", 0, 0, 0);
        exp_q.delete();
        ps2_clk = 1'b1;
        repeat (5) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (20) @(negedge HCLK);
        chk("rst_after_count", int'(bus.count), 0);
        send_frame(8'h5A, 1'b0, 1'b1, 0, 11, 1'b0);
        exp_q.push_back(8'h5A);
        chk("rst_next_count", int'(bus.count), 1);
        chk_flags("rst_next", 0, 0, 0);
        pop_check("rst_next_data");
        pop_check("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- PS/2 device-to-host receiver with a byte FIFO. It feeds the GPIO block's PS/2 interrupt/data path.
- Synchronises and deglitches the raw PS/2 clock and data pins, deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop) and queues good bytes.
- Presents the FIFO head with a ready flag and a single-cycle pop strobe.
- Runs entirely in the HCLK domain; the PS/2 pins are asynchronous inputs.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- FILTER, 8, consecutive identical synchronised samples required before the filtered PS/2 clock changes; range 2..255.
- TIMEOUT, 50000, HCLK cycles without a filtered falling edge before a partial frame is aborted; minimum 16.

Ports:
- HCLK  in  1  system clock; every flop in the block uses its rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- rd  in  1  pop strobe; one pop per cycle in which it is high.
- clr_err  in  1  clears the sticky error flags.
- data  out  8  FIFO head byte (show-ahead); valid while ready=1.
- ready  out  1  FIFO non-empty.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: a good byte was dropped because the FIFO was full.
- parity_err  out  1  sticky: a frame was discarded for bad parity.
- frame_err  out  1  sticky: bad stop bit or timeout abort.

Behaviour:
- Reset: all outputs 0. FIFO empty, pointers 0, FSM in IDLE, timeout counter 0. The filtered clock and its previous-value register reset to 1.
- Synchroniser: 2-flop synchroniser on each pin.
- Clock filter: a counter increments while the synchronised clock differs from the filtered value, and clears when they match. When the counter reaches FILTER-1, the filtered value takes the synchronised value and the counter clears.
- Data is not filtered. It is sampled from its synchroniser output on the fall pulse.
- fall: one-cycle pulse when previous filtered = 1 and current filtered = 0.
- FSM IDLE:
  - fall with data=0: go to DATA, bit index 0, clear the shift register.
  - fall with data=1: ignore the edge and stay in IDLE. No error.
- FSM DATA: on each fall, shift data in LSB-first. After the 8th bit (index 7) go to PARITY.
- FSM PARITY: on fall, store the parity bit and go to STOP. Parity is good when XOR(8 data bits, parity bit) = 1.
- FSM STOP: on fall, go to IDLE, then:
  - stop=1 and parity good: push the byte.
  - stop=1 and parity bad: set parity_err, discard the byte.
  - stop=0: set frame_err, discard the byte. This applies whatever the parity result.
- Timeout:
  - In DATA, PARITY and STOP, the timeout counter increments each cycle and clears on fall.
  - When it reaches TIMEOUT-1, the FSM goes to IDLE, frame_err is set and the counter clears.
  - In IDLE the counter is held at 0.
- Push latency: the push happens at the clock edge where the STOP fall is seen. ready, count and data reflect it on the next cycle.
- Pop: rd=1 with ready=1 advances the read pointer; data shows the next entry the following cycle. rd with ready=0 is ignored and count does not underflow.
- Full: a push when count=DEPTH and no pop in that cycle drops the byte and sets overflow. The FIFO contents are unchanged.
- Simultaneous push and pop:
  - Both are performed and count is unchanged.
  - When full, the push is accepted and overflow is not set.
  - When empty, the pop is ignored and the push proceeds.
- Pointers: $clog2(DEPTH) bits, wrapping modulo DEPTH. count is the occupancy register.
- Sticky flags: overflow, parity_err and frame_err hold until clr_err=1.
  - clr_err clears all three next cycle.
  - A set event in the same cycle as clr_err wins: the flag stays 1.
- Async reset mid-frame: immediate return to reset state. The partial frame is lost; no flag is set.

Test Plan:
- Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at a 10 kHz PS/2 clock -> ready=1, data=0x1C, count=1 one cycle after the stop fall. rd pulse -> ready=0, count=0.
- Frame 0x1C with parity 1 -> no push, parity_err=1, count=0. clr_err -> parity_err=0. Frame 0xF0 with parity 1 -> data=0xF0.
- Frame 0x55 with stop=0 -> frame_err=1, no push. Abandon a frame after 4 data bits, wait TIMEOUT cycles -> frame_err=1, FSM in IDLE. Then a valid 0x29 frame is received correctly.
- 9 good frames 0x01..0x09 with DEPTH=8 and no pops -> count=8, overflow=1. Popping all yields 0x01..0x08 in order; 0x09 is lost.
- With FIFO full, assert rd on the exact cycle the 9th stop fall is seen -> count stays 8, overflow=0. Popping all yields 0x02..0x09.
- Glitch pulses on ps2_clk shorter than FILTER cycles mid-frame -> ignored, byte received intact. Assert HRESETn=0 mid-frame -> all outputs 0 immediately; the next full frame is received correctly.
